// File: rtl/glip_tx_channel_arbiter_if.sv
// Stream bundle between the logic-side channels, the arbiter and the toplevel fifo_out port.
// A word moves when valid && ready are both high at a rising clk edge; valid never waits on ready.
interface glip_tx_channel_arbiter_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [WIDTH-1:0]          out_data;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/glip_tx_channel_arbiter.sv
// Round-robin arbiter sharing one fifo_out stream between CHANNELS producers.
// Each grant emits a channel-id header word, then up to MAX_BURST data words.
module glip_tx_channel_arbiter #(
    parameter int          WIDTH      = 16,
    parameter int          CHANNELS   = 4,
    parameter int          MAX_BURST  = 64,
    parameter logic [7:0]  HEADER_TAG = 8'hA5
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_arb_enable,
    glip_tx_channel_arbiter_if.slave     io_bus,
    output logic [CHANNELS-1:0]          o_grant,
    output logic                         o_burst_active,
    output logic [1:0]                   o_state
);

    localparam int PTR_W = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_HEADER = 2'd1,
        S_BURST  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_rr_ptr;
    logic [PTR_W-1:0] r_sel;
    logic [PTR_W-1:0] w_pick;
    logic             w_found;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_header;
    logic [WIDTH-1:0] w_header;
    logic             w_start;
    logic             w_beat;
    logic             w_done;

    // First requester at or after r_rr_ptr, wrapping modulo CHANNELS.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!w_found && io_bus.in_valid[(int'(r_rr_ptr) + i) % CHANNELS]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'((int'(r_rr_ptr) + i) % CHANNELS);
            end
        end
    end

    always_comb begin
        w_header        = '0;
        w_header[15:8]  = HEADER_TAG;
        w_header[3:0]   = 4'(w_pick);
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_start           = 1'b0;
        w_beat            = 1'b0;
        w_done            = 1'b0;
        io_bus.out_valid  = 1'b0;
        io_bus.out_data   = r_header;
        io_bus.in_ready   = '0;
        o_grant           = '0;
        o_burst_active    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_arb_enable && w_found) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_HEADER;
                end
            end
            S_HEADER: begin
                io_bus.out_valid = 1'b1;
                o_grant[r_sel]   = 1'b1;
                o_burst_active   = 1'b1;
                if (io_bus.out_ready) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                io_bus.out_valid       = io_bus.in_valid[r_sel];
                io_bus.out_data        = io_bus.in_data[r_sel*WIDTH +: WIDTH];
                io_bus.in_ready[r_sel] = io_bus.out_ready;
                o_grant[r_sel]         = 1'b1;
                o_burst_active         = 1'b1;
                // A gap on the owning channel ends the burst without losing a word.
                if (!io_bus.in_valid[r_sel]) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (io_bus.out_ready) begin
                    w_beat = 1'b1;
                    if (r_cnt == CNT_W'(MAX_BURST - 1)) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign o_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_sel    <= '0;
            r_cnt    <= '0;
            r_header <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_sel    <= w_pick;
                r_header <= w_header;
                r_cnt    <= '0;
            end
            if (w_beat) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_done) begin
                r_rr_ptr <= (r_sel == PTR_W'(CHANNELS - 1)) ? '0 : r_sel + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_glip_tx_channel_arbiter.sv
// Bench for glip_tx_channel_arbiter: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model of grant, header and word order.
module tb_glip_tx_channel_arbiter;

    localparam int WIDTH     = 16;
    localparam int CHANNELS  = 4;
    localparam int MAX_BURST = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                arb_enable = 1'b0;
    logic [CHANNELS-1:0] grant;
    logic                burst_active;
    logic [1:0]          dbg_state;

    glip_tx_channel_arbiter_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) bus ();

    glip_tx_channel_arbiter #(
        .WIDTH(WIDTH), .CHANNELS(CHANNELS), .MAX_BURST(MAX_BURST), .HEADER_TAG(8'hA5)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_arb_enable   (arb_enable),
        .io_bus         (bus),
        .o_grant        (grant),
        .o_burst_active (burst_active),
        .o_state        (dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: owner = channel holding the stream (-1 none), hdr = header still owed.
    int m_owner = -1;
    int m_hdr   = 0;
    int m_cnt   = 0;
    int m_rr    = 0;
    int exp_seq[CHANNELS];
    int prod_seq[CHANNELS];
    logic [WIDTH-1:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_hdr   = 0;
        m_cnt   = 0;
        m_rr    = 0;
    endtask

    // Called right after a negedge with in_valid/out_ready/arb_enable set; ends at the next negedge.
    task automatic cycle();
        logic [CHANNELS-1:0] e_ready;
        logic [CHANNELS-1:0] e_grant;
        logic                e_valid;
        logic                e_active;
        logic [WIDTH-1:0]    e_data;
        logic                found;
        int                  idx;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.in_data[c*WIDTH +: WIDTH] = {4'(c), 12'(prod_seq[c])};
        end
        #1;
        e_ready  = '0;
        e_grant  = '0;
        e_valid  = 1'b0;
        e_active = 1'b0;
        e_data   = '0;
        if (m_owner >= 0) begin
            e_grant[m_owner] = 1'b1;
            e_active         = 1'b1;
            if (m_hdr != 0) begin
                e_valid = 1'b1;
                e_data  = 16'hA500 | 16'(m_owner);
            end else begin
                e_valid          = bus.in_valid[m_owner];
                e_data           = {4'(m_owner), 12'(exp_seq[m_owner])};
                e_ready[m_owner] = bus.out_ready;
            end
        end
        check_eq("out_valid", bus.out_valid, e_valid);
        check_eq("burst_active", burst_active, e_active);
        check_eq("grant", grant, e_grant);
        check_eq("in_ready", bus.in_ready, e_ready);
        if (e_valid) check_eq("out_data", bus.out_data, e_data);

        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.in_valid[c] && bus.in_ready[c]) prod_seq[c]++;
        end
        if (e_valid && bus.out_ready) exp_q.push_back(e_data);
        if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check_eq("out_extra_word", 1, 0);
            else check_eq("out_word", bus.out_data, exp_q.pop_front());
        end

        if (m_owner < 0) begin
            if (arb_enable && (|bus.in_valid)) begin
                found = 1'b0;
                for (int k = 0; k < CHANNELS; k++) begin
                    idx = (m_rr + k) % CHANNELS;
                    if (!found && bus.in_valid[idx]) begin
                        found   = 1'b1;
                        m_owner = idx;
                    end
                end
                m_hdr = 1;
                m_cnt = 0;
            end
        end else if (m_hdr != 0) begin
            if (bus.out_ready) m_hdr = 0;
        end else if (!bus.in_valid[m_owner]) begin
            m_rr    = (m_owner + 1) % CHANNELS;
            m_owner = -1;
        end else if (bus.out_ready) begin
            exp_seq[m_owner]++;
            m_cnt++;
            if (m_cnt == MAX_BURST) begin
                m_rr    = (m_owner + 1) % CHANNELS;
                m_owner = -1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_in_ready", bus.in_ready, 0);
        check_eq("rst_burst_active", burst_active, 0);
        check_eq("rst_out_data", bus.out_data, 0);
        model_reset();
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run(input logic [CHANNELS-1:0] valid, input logic ready, input logic en, input int n);
        for (int i = 0; i < n; i++) begin
            bus.in_valid  = valid;
            bus.out_ready = ready;
            arb_enable    = en;
            cycle();
        end
    endtask

    task automatic drain();
        run('0, 1'b1, 1'b1, 4);
    endtask

    initial begin
        for (int c = 0; c < CHANNELS; c++) begin
            exp_seq[c]  = 0;
            prod_seq[c] = 0;
        end
        bus.in_valid  = '0;
        bus.out_ready = 1'b0;
        bus.in_data   = '0;
        #2;
        do_reset();

        // Two continuous requesters: H(0), 4 words, idle, H(2), 4 words, idle, H(0)...
        run(4'b0101, 1'b1, 1'b1, 24);
        drain();

        // Channel 3 sends two words then drops valid; next grant starts from channel 0.
        run(4'b1000, 1'b1, 1'b1, 4);
        run(4'b0000, 1'b1, 1'b1, 2);
        run(4'b1001, 1'b1, 1'b1, 8);
        drain();

        // Reset while channel 1 is mid-burst with a moved rr pointer.
        run(4'b0000, 1'b1, 1'b1, 4);
        run(4'b0100, 1'b1, 1'b1, 7);
        run(4'b0010, 1'b1, 1'b1, 10);
        do_reset();
        run(4'b0110, 1'b1, 1'b1, 8);
        drain();

        // out_ready toggling 1010 through header and burst.
        for (int i = 0; i < 24; i++) run(4'b0001, 1'(i % 2 == 0), 1'b1, 1);
        drain();

        // arb_enable dropped after the grant: burst completes, no new header until re-enabled.
        run(4'b0010, 1'b1, 1'b1, 1);
        run(4'b0010, 1'b1, 1'b0, 15);
        run(4'b0010, 1'b1, 1'b1, 6);
        drain();

        // Random traffic.
        for (int i = 0; i < 10000; i++) begin
            logic [CHANNELS-1:0] v;
            for (int c = 0; c < CHANNELS; c++) v[c] = ($urandom_range(0, 3) != 0);
            run(v, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) != 0), 1);
        end
        drain();

        check_eq("exp_q_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
